// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_conditioner_pkg                                            |
// | Shared lift-controller constants and input-normalisation helper. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package input_conditioner_pkg;

  localparam int c_NUM_CH = 3;

  localparam int c_P1  = 0;
  localparam int c_P2  = 1;
  localparam int c_P3  = 2;
  localparam int c_FC1 = 0;
  localparam int c_FC2 = 1;
  localparam int c_FC3 = 2;

  typedef enum logic [1:0] {
    MOTOR_STOP = 2'b00,
    MOTOR_UP   = 2'b01,
    MOTOR_DN   = 2'b10
  } motor_e;

  localparam logic [3:0] c_DISP_OFF = 4'hF;

  // Maps a raw pin level to "1 = active" regardless of pull direction.
  function automatic logic normalise(input logic raw, input bit act_low);
    return raw ^ act_low;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_conditioner_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_conditioner_if                                             |
// | Raw button/endstop inputs and conditioned outputs of the front   |
// | end. Rev 1.0                                                     |
// +------------------------------------------------------------------+
interface input_conditioner_if;
  import input_conditioner_pkg::*;

  logic [c_NUM_CH-1:0] btn_raw;
  logic [c_NUM_CH-1:0] end_raw;
  logic [c_NUM_CH-1:0] button_pulse;
  logic [c_NUM_CH-1:0] endstop_lvl;

  modport master (
    output btn_raw,
    output end_raw,
    input  button_pulse,
    input  endstop_lvl
  );

  modport slave (
    input  btn_raw,
    input  end_raw,
    output button_pulse,
    output endstop_lvl
  );

endinterface
`default_nettype wire

// File: rtl/input_conditioner_debounce_ch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_ch                                                      |
// | One channel: normalise, 2-FF synchronise, symmetric debounce.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module debounce_ch
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit ACT_LOW         = 1'b1
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;

  assign w_accept = (r_sync2 != level) && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
    end else begin
      r_sync1 <= normalise(raw, ACT_LOW);
      r_sync2 <= r_sync1;
      // Pulse is registered alongside level so both appear on the same edge.
      rise    <= w_accept && r_sync2;
      if (r_sync2 == level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        level <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | input_conditioner                                                |
// | Debounced call-button pulses and endstop levels for the FSM.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter bit BTN_ACT_LOW     = 1'b1,
  parameter bit END_ACT_LOW     = 1'b1
) (
  input  wire                 clk,
  input  wire                 rst,
  input_conditioner_if.slave  bus
);

  // Buttons only need the press event, endstops only the level.
  logic [c_NUM_CH-1:0] w_btn_level_unused;
  logic [c_NUM_CH-1:0] w_end_rise_unused;

  generate
    for (genvar i = 0; i < c_NUM_CH; i++) begin : g_btn
      debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACT_LOW         (BTN_ACT_LOW)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_raw[i]),
        .level (w_btn_level_unused[i]),
        .rise  (bus.button_pulse[i])
      );
    end

    for (genvar i = 0; i < c_NUM_CH; i++) begin : g_end
      debounce_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .ACT_LOW         (END_ACT_LOW)
      ) u_ch (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.end_raw[i]),
        .level (bus.endstop_lvl[i]),
        .rise  (w_end_rise_unused[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_input_conditioner                                             |
// | Directed and random stimulus against a window-based debounce     |
// | reference model. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_input_conditioner;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  input_conditioner_if bus ();

  input_conditioner #(
    .DEBOUNCE_CYCLES (N),
    .CNT_W           (4),
    .BTN_ACT_LOW     (1'b1),
    .END_ACT_LOW     (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: bits 2:0 buttons, 5:3 endstops, 1 = active. A channel's stable
  // value flips when the N samples taken before the last two (synchroniser
  // delay) all disagree with it; a button pulses on the edge its value rises.
  logic [5:0] hist[$];
  logic [5:0] m_stb;
  logic [5:0] m_pulse;
  logic [5:0] m_prev;
  logic       m_all;

  initial begin : model
    m_stb   = '0;
    m_pulse = '0;
    for (int k = 0; k < N + 2; k++) hist.push_back(6'b0);
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        hist.delete();
        for (int k = 0; k < N + 2; k++) hist.push_back(6'b0);
        m_stb   = '0;
        m_pulse = '0;
      end else begin
        hist.push_back(~{bus.end_raw, bus.btn_raw});
        void'(hist.pop_front());
        m_prev = m_stb;
        for (int ch = 0; ch < 6; ch++) begin
          m_all = 1'b1;
          for (int j = 0; j < N; j++)
            if (hist[j][ch] == m_stb[ch]) m_all = 1'b0;
          if (m_all) m_stb[ch] = ~m_stb[ch];
        end
        m_pulse = m_stb & ~m_prev & 6'b000111;
      end
    end
  end

  task automatic test_reset();
    bus.btn_raw = 3'b111;
    bus.end_raw = 3'b111;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.button_pulse !== 3'b000 || bus.endstop_lvl !== 3'b000) begin
      failures++;
      $display("FAIL reset_state pulse=%b lvl=%b expected 000/000", bus.button_pulse, bus.endstop_lvl);
    end
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (bus.button_pulse !== 3'b000 || bus.endstop_lvl !== 3'b000) begin
        failures++;
        $display("FAIL idle_after_reset pulse=%b lvl=%b expected 000/000", bus.button_pulse, bus.endstop_lvl);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    bus.btn_raw = 3'b101;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      exp = (e == 6) ? 3'b010 : 3'b000;
      checks++;
      if (bus.button_pulse !== exp) begin
        failures++;
        $display("FAIL clean_press edge=%0d pulse=%b expected=%b", e, bus.button_pulse, exp);
      end
      checks++;
      if (bus.button_pulse !== m_pulse[2:0]) begin
        failures++;
        $display("FAIL clean_press_model edge=%0d pulse=%b model=%b", e, bus.button_pulse, m_pulse[2:0]);
      end
    end
    bus.btn_raw = 3'b111;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_pulse !== 3'b000) begin
        failures++;
        $display("FAIL release_no_pulse edge=%0d pulse=%b expected=000", e, bus.button_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        bus.btn_raw = (c < 2) ? 3'b110 : 3'b111;
        @(negedge clk);
        checks++;
        if (bus.button_pulse !== 3'b000) begin
          failures++;
          $display("FAIL bounce r=%0d c=%0d pulse=%b expected=000", r, c, bus.button_pulse);
        end
      end
    end
    bus.btn_raw = 3'b111;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      checks++;
      if (bus.button_pulse !== 3'b000 || m_pulse[2:0] !== 3'b000) begin
        failures++;
        $display("FAIL bounce_tail edge=%0d pulse=%b model=%b expected=000", e, bus.button_pulse, m_pulse[2:0]);
      end
    end
  endtask

  task automatic test_endstop();
    logic exp;
    for (int e = 1; e <= 32; e++) begin
      // Low from step 0, 3-step release glitch at steps 8..10, high from step 20.
      bus.end_raw[2] = ((e - 1 < 8) || (e - 1 >= 11 && e - 1 < 20)) ? 1'b0 : 1'b1;
      @(negedge clk);
      exp = (e >= 6 && e <= 25);
      checks++;
      if (bus.endstop_lvl !== {exp, 2'b00}) begin
        failures++;
        $display("FAIL endstop edge=%0d lvl=%b expected=%b", e, bus.endstop_lvl, {exp, 2'b00});
      end
      checks++;
      if (bus.endstop_lvl !== m_stb[5:3]) begin
        failures++;
        $display("FAIL endstop_model edge=%0d lvl=%b model=%b", e, bus.endstop_lvl, m_stb[5:3]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp;
    for (int rep = 0; rep < 2; rep++) begin
      bus.btn_raw = 3'b000;
      for (int e = 1; e <= 10; e++) begin
        @(negedge clk);
        exp = (e == 6) ? 3'b111 : 3'b000;
        checks++;
        if (bus.button_pulse !== exp) begin
          failures++;
          $display("FAIL simultaneous rep=%0d edge=%0d pulse=%b expected=%b", rep, e, bus.button_pulse, exp);
        end
      end
      bus.btn_raw = 3'b111;
      for (int e = 1; e <= 10; e++) begin
        @(negedge clk);
        checks++;
        if (bus.button_pulse !== 3'b000) begin
          failures++;
          $display("FAIL simultaneous_release rep=%0d edge=%0d pulse=%b expected=000", rep, e, bus.button_pulse);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] exp;
    bus.end_raw = 3'b110;
    repeat (8) @(negedge clk);
    checks++;
    if (bus.endstop_lvl !== 3'b001) begin
      failures++;
      $display("FAIL pre_reset_endstop lvl=%b expected=001", bus.endstop_lvl);
    end
    bus.btn_raw = 3'b110;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.button_pulse !== 3'b000 || bus.endstop_lvl !== 3'b000) begin
      failures++;
      $display("FAIL async_reset pulse=%b lvl=%b expected 000/000", bus.button_pulse, bus.endstop_lvl);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      exp = (e == 6) ? 3'b001 : 3'b000;
      checks++;
      if (bus.button_pulse !== exp) begin
        failures++;
        $display("FAIL post_reset_pulse edge=%0d pulse=%b expected=%b", e, bus.button_pulse, exp);
      end
      exp = (e >= 6) ? 3'b001 : 3'b000;
      checks++;
      if (bus.endstop_lvl !== exp) begin
        failures++;
        $display("FAIL post_reset_endstop edge=%0d lvl=%b expected=%b", e, bus.endstop_lvl, exp);
      end
    end
    bus.btn_raw = 3'b111;
    bus.end_raw = 3'b111;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0] base;
    logic [5:0] drv;
    base = 6'h3F;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) base = 6'($urandom);
      drv = base;
      if ($urandom_range(0, 7) == 0) drv[$urandom_range(0, 5)] ^= 1'b1;
      {bus.end_raw, bus.btn_raw} = drv;
      @(negedge clk);
      checks++;
      if (bus.button_pulse !== m_pulse[2:0] || bus.endstop_lvl !== m_stb[5:3]) begin
        failures++;
        $display("FAIL random cyc=%0d pulse=%b lvl=%b model_pulse=%b model_lvl=%b",
                 c, bus.button_pulse, bus.endstop_lvl, m_pulse[2:0], m_stb[5:3]);
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_clean_press();
    test_bounce();
    test_endstop();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
